ex_muldiv_seq: RTL
==================

// Module: ex_muldiv_seq
// PURPOSE
//   Multi-cycle sequencer for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU in EX.
//   - Latches forwarded operands from the EX stage (post-forwarding rs1/rs2 data).
//   - Runs an iterative radix-2 shift-add multiply or restoring divide.
//   - Stalls the pipeline until the result is ready.
//   - Hands the result to EX for muxing into ex_d_alu_csr_result.
// PARAMETERS
//   XLEN      32  operand/result width
//   FAST_MUL  0   1: multiply uses a single-cycle '*' in one BUSY cycle; 0: iterative
// PORTS
//   clk              in   1     system clock
//   rst              in   1     reset, asynchronous, active-high
//   ex_valid         in   1     EX holds a valid instruction
//   ex_trap_valid    in   1     EX instruction already carries a trap; never start
//   ex_is_muldiv     in   1     EX instruction is an M-extension op
//   ex_muldiv_op     in   3     funct3 encoding, muldiv_op_e
//   ex_src_a         in   XLEN  forwarded rs1 data
//   ex_src_b         in   XLEN  forwarded rs2 data
//   ex_hold          in   1     downstream stall; EX cannot advance this cycle
//   ex_flush         in   1     EX instruction is being killed
//   ex_muldiv_stall  out  1     freeze IF..EX; EX must not advance
//   ex_muldiv_done   out  1     ex_muldiv_result is valid for the EX instruction
//   ex_muldiv_result out  XLEN  final result
// BEHAVIOUR
//   Reset (async, rst=1):
//     - FSM = IDLE; counter = 0; internal registers = 0.
//     - stall = 0, done = 0, result = 0.
//   start = ex_valid & ex_is_muldiv & ~ex_trap_valid & ~ex_flush, sampled in IDLE only.
//   stall is combinational: (IDLE & start) | BUSY. It is 0 in DONE.
//   FSM states:
//     IDLE -> BUSY on start (normal case).
//       - Latch op and |a|,|b| per signedness.
//       - Latch sign-fix flags; counter = XLEN-1.
//     IDLE -> DONE on start when a special divide case applies:
//       - Divide by zero: quotient = all ones; remainder = dividend (signed and unsigned).
//       - Signed overflow (a = 0x80000000, b = -1): DIV = 0x80000000, REM = 0.
//     BUSY: one radix-2 step per cycle; counter decrements.
//       - When counter == 0: apply sign fix, register result, go to DONE.
//       - FAST_MUL = 1 and a multiply op: exactly one BUSY cycle.
//     DONE: done = 1; result held stable.
//       - If ~ex_hold: go to IDLE (the instruction leaves EX this cycle).
//       - If ex_hold: stay in DONE; do not restart the same instruction.
//   Latency, with start in cycle 0:
//     - Iterative op: BUSY in cycles 1..XLEN; DONE in cycle XLEN+1.
//     - Special divide case: DONE in cycle 1.
//     - FAST_MUL multiply: DONE in cycle 2.
//   Arithmetic:
//     - Multiply keeps a 2*XLEN product.
//       - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
//       - MULHSU: a signed, b unsigned.
//     - Divide keeps quotient and remainder registers.
//       - Quotient negated iff signs differ.
//       - Remainder takes the sign of the dividend.
//   ex_flush in any state: next state IDLE, stall = 0 next cycle, result discarded.
//     - Flush overrides a same-cycle start.
//   rst mid-operation: immediate abort to the reset values above.
//   ex_is_muldiv = 0 in IDLE: outputs stay 0/idle; result keeps its last value.
// STRUCTURE
//   riscv_pkg additions:
//     - muldiv_op_e: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
//     - muldiv_state_e: IDLE, BUSY, DONE.
//   Single module with no sub-module. FSM, counter and shift datapath live together.
//   Top level: ex_stage result mux selects ex_muldiv_result when ex_is_muldiv.
//   Top level: hazard logic ORs ex_muldiv_stall into the IF/ID/EX stall.
// TESTING
//   1. MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; done in cycle 33; stall high cycles 0..32.
//   2. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
//      MULH a=0x80000000, b=0x80000000 -> 0x40000000.
//   3. DIVU 100/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, done in cycle 1.
//      DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
//   4. DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF.
//      DIVU 0xFFFFFFFE/3 -> 0x55555554.
//   5. ex_flush in cycle 10 of a DIV -> stall 0 in cycle 11, state IDLE.
//      New request in cycle 12 completes with the correct result.
//   6. ex_hold high for 3 cycles in DONE -> done/result stable, no restart.
//      ex_hold drops -> IDLE next cycle. Also: rst asserted mid-BUSY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ex_muldiv_seq_pkg.sv
// Shared types for the EX-stage RV32M multiply/divide sequencer.
// Op encoding follows funct3 of the M-extension instructions.
package ex_muldiv_seq_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    function automatic logic md_is_mul(input muldiv_op_e op);
        return ~op[2];
    endfunction

    function automatic logic md_is_rem(input muldiv_op_e op);
        return op[2] & op[1];
    endfunction

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM
    function automatic logic md_signed_a(input muldiv_op_e op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM
    function automatic logic md_signed_b(input muldiv_op_e op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_seq.sv
// Multi-cycle RV32M sequencer: radix-2 shift-add multiply, restoring divide.
// Works on magnitudes and applies the sign fix on the last step.
import ex_muldiv_seq_pkg::*;

module ex_muldiv_seq #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_trap_valid,
    input  logic            ex_is_muldiv,
    input  logic [2:0]      ex_muldiv_op,
    input  logic [XLEN-1:0] ex_src_a,
    input  logic [XLEN-1:0] ex_src_b,
    input  logic            ex_hold,
    input  logic            ex_flush,
    output logic            ex_muldiv_stall,
    output logic            ex_muldiv_done,
    output logic [XLEN-1:0] ex_muldiv_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e   state_q;
    muldiv_op_e      op_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] result_q;

    muldiv_op_e      op_in;
    logic            start;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            b_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_rs;
    logic              div_ge;
    logic [XLEN-1:0]   hi_d;
    logic [XLEN-1:0]   lo_d;
    logic [2*XLEN-1:0] prod_raw;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;
    logic [XLEN-1:0]   fin_res;
    logic              last_step;

    assign op_in = muldiv_op_e'(ex_muldiv_op);
    assign start = ex_valid & ex_is_muldiv & ~ex_trap_valid & ~ex_flush;

    assign a_neg = md_signed_a(op_in) & ex_src_a[XLEN-1];
    assign b_neg = md_signed_b(op_in) & ex_src_b[XLEN-1];
    assign a_abs = a_neg ? -ex_src_a : ex_src_a;
    assign b_abs = b_neg ? -ex_src_b : ex_src_b;

    assign b_zero  = (ex_src_b == '0);
    assign div_ovf = md_signed_a(op_in) & (ex_src_a == MIN_NEG) & (&ex_src_b);
    assign special = ~md_is_mul(op_in) & (b_zero | div_ovf);

    // Divide-by-zero and signed-overflow results, resolved without iterating
    always_comb begin
        special_res = '0;
        if (b_zero) begin
            special_res = md_is_rem(op_in) ? ex_src_a : '1;
        end else if (!md_is_rem(op_in)) begin
            special_res = MIN_NEG;
        end
    end

    // One radix-2 step: hi/lo hold product halves or remainder/quotient
    always_comb begin
        mul_sum = '0;
        div_rs  = '0;
        div_ge  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (md_is_mul(op_q)) begin
            mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
            hi_d    = mul_sum[XLEN:1];
            lo_d    = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
            div_rs = {hi_q, lo_q[XLEN-1]};
            div_ge = (div_rs >= {1'b0, mcand_q});
            hi_d   = div_ge ? (div_rs[XLEN-1:0] - mcand_q) : div_rs[XLEN-1:0];
            lo_d   = {lo_q[XLEN-2:0], div_ge};
        end
    end

    // Sign fix and result selection applied on the final step
    always_comb begin
        if (FAST_MUL) begin
            prod_raw = {{XLEN{1'b0}}, mcand_q} * {{XLEN{1'b0}}, lo_q};
        end else begin
            prod_raw = {hi_d, lo_d};
        end
        prod_fix = neg_q ? -prod_raw : prod_raw;
        q_fix    = neg_q ? -lo_d : lo_d;
        r_fix    = neg_q ? -hi_d : hi_d;
        unique case (op_q)
            MUL:                 fin_res = prod_fix[XLEN-1:0];
            MULH, MULHSU, MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
            DIV, DIVU:           fin_res = q_fix;
            default:             fin_res = r_fix;
        endcase
    end

    assign last_step = (cnt_q == '0) | (FAST_MUL & md_is_mul(op_q));

    // Sequencer FSM with its counter and shift datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= MUL;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else if (ex_flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q <= op_in;
                        if (special) begin
                            result_q <= special_res;
                            state_q  <= DONE;
                        end else begin
                            mcand_q <= md_is_mul(op_in) ? a_abs : b_abs;
                            lo_q    <= md_is_mul(op_in) ? b_abs : a_abs;
                            hi_q    <= '0;
                            neg_q   <= md_is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
                            cnt_q   <= CW'(XLEN-1);
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (last_step) begin
                        result_q <= fin_res;
                        cnt_q    <= '0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (!ex_hold) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stall asks for the cycle a start is seen and every BUSY cycle
    assign ex_muldiv_stall  = ~rst & (((state_q == IDLE) & start) | (state_q == BUSY));
    assign ex_muldiv_done   = (state_q == DONE);
    assign ex_muldiv_result = result_q;

endmodule
